vid_stream_meas: RTL and testbench
==================================

// Module: vid_stream_meas
// PURPOSE
//  Receive end of the scaler video stream (di/de/hs/vs). Sits after scaler/scaler_bilinear in HW and in benches.
//  Measures active width, height and pixel checksum of each frame; flags malformed streams.
//  Results are published once per frame for register readout and for self-checking in benches.
// PARAMETERS
//  PIXEL_WIDTH  8   pixel bits on di_i
//  CNT_WIDTH    16  width of pixel/line/frame counters; all counters saturate at all-ones
//  SUM_WIDTH    32  checksum width; sum of pixels modulo 2^SUM_WIDTH
// PORTS
//  clk             in   1            single clock domain
//  rst             in   1            synchronous, active-high reset
//  di_i            in   PIXEL_WIDTH  pixel data, valid when de_i=1
//  de_i            in   1            pixel valid; may be sparse (gaps between pixels allowed)
//  hs_i            in   1            1 = horizontal blank; 0 = inside line
//  vs_i            in   1            1 = inside frame; 0 = vertical blank
//  err_clr_i       in   1            clears sticky error flags
//  frame_w_o       out  CNT_WIDTH    pixels in first non-empty line of last frame
//  frame_h_o       out  CNT_WIDTH    non-empty lines in last frame
//  frame_sum_o     out  SUM_WIDTH    sum of all pixels of last frame
//  frame_cnt_o     out  CNT_WIDTH    completed frames since reset
//  frame_done_o    out  1            1-cycle pulse when the outputs above update
//  err_line_len_o  out  1            sticky: a line length differed from first line of same frame
//  err_de_blank_o  out  1            sticky: de_i=1 while hs_i=1 or vs_i=0
// BEHAVIOUR
//  - Reset: all outputs 0; FSM -> SYNC; all internal counters 0.
//  - Inputs registered once; edges detected on registered copies vs previous sample.
//  - Pixel accepted: de=1 & hs=0 & vs=1 & FSM in LINE; line_cnt++ , sum += di.
//  - FSM states:
//    SYNC  : wait for vs=0 (never measure partial frame) -> IDLE.
//    IDLE  : vs rising edge -> FRAME; clear line/height/sum accumulators.
//    FRAME : hs falling edge -> LINE (pix counter = 0); vs falling edge -> PUBLISH.
//    LINE  : hs rising edge -> close line, -> FRAME; vs falling edge -> close line then PUBLISH.
//    PUBLISH: one cycle; load outputs, frame_cnt_o++, pulse frame_done_o -> IDLE.
//  - Close line: if pix count = 0 ignore line. Else h++; first line of frame sets width;
//    later lines with count /= width set err_line_len_o.
//  - Simultaneous hs rising + vs falling (normal last line): line closed and counted before publish.
//  - Pixel on the same cycle as hs rising edge is not counted (hs=1 is blank).
//  - Latency: frame_done_o high in the cycle after the 2nd clk edge following the edge at which vs_i=0
//    is first sampled (1 input reg + 1 close/publish stage); outputs stable until next PUBLISH.
//  - Frame with zero non-empty lines: still published, w=h=sum=0.
//  - err_clr_i clears sticky flags; an error detected in the same cycle wins (flag stays 1).
//  - err_de_blank_o checked in every state except SYNC.
//  - Counter saturation: pix/line/frame counters stop at 2^CNT_WIDTH-1, never wrap; sum wraps.
//  - rst mid-frame: accumulators dropped, no frame_done_o for that frame, re-enter SYNC.
// STRUCTURE
//  - Package vid_pkg: state enum meas_state_t {SYNC,IDLE,FRAME,LINE,PUBLISH}, default CNT_WIDTH.
//  - Sub-module vid_edge_det (registered rise/fall pulse for one bit), instanced for hs and vs.
//  - Remaining logic (FSM, counters, checker) in this file.
// TESTING
//  1 24x24 frame, dense de, di=x+y -> w=24 h=24 sum=13248 frame_done_o one pulse, no errors.
//  2 Same frame with 3 idle cycles per pixel (sparse de) -> identical w/h/sum as case 1.
//  3 Line 5 has 23 pixels, others 24 -> err_line_len_o=1, w=24 h=24; err_clr_i -> flag 0.
//  4 de_i=1 for one cycle with hs_i=1 between lines -> err_de_blank_o=1, pixel not in sum.
//  5 Last line: hs_i rises and vs_i falls same cycle -> h=24 (not 23), frame_cnt_o increments by 1.
//  6 rst asserted at line 10, released mid-frame -> no frame_done_o for that frame;
//    next full 24x24 frame measured as case 1 with frame_cnt_o=1.

Source files
------------

// File: rtl/vid_stream_meas_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// vid_pkg : shared types and defaults for the video stream meter
// Rev 1.0
// ------------------------------------------------------------------
package vid_pkg;

  localparam int c_CNT_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    IDLE    = 3'd1,
    FRAME   = 3'd2,
    LINE    = 3'd3,
    PUBLISH = 3'd4
  } meas_state_t;

endpackage
`default_nettype wire

// File: rtl/vid_stream_meas_if.sv
`default_nettype none
// ------------------------------------------------------------------
// vid_stream_meas_if : pixel stream bundle (data, valid, hblank, vframe)
// Rev 1.0
// ------------------------------------------------------------------
interface vid_stream_meas_if #(
  parameter int PIXEL_WIDTH = 8
);

  logic [PIXEL_WIDTH-1:0] di;
  logic                   de;
  logic                   hs;
  logic                   vs;

  modport master (output di, de, hs, vs);
  modport slave  (input  di, de, hs, vs);

endinterface
`default_nettype wire

// File: rtl/vid_stream_meas_edge_det.sv
`default_nettype none
// ------------------------------------------------------------------
// vid_edge_det : rise/fall pulses of one bit against its previous sample
// Rev 1.0
// ------------------------------------------------------------------
module vid_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = d_i & ~prev_q;
  assign fall_o = ~d_i & prev_q;

endmodule
`default_nettype wire

// File: rtl/vid_stream_meas.sv
`default_nettype none
// ------------------------------------------------------------------
// vid_stream_meas : per-frame width/height/checksum meter with stream checks
// Rev 1.0
// ------------------------------------------------------------------
module vid_stream_meas
  import vid_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = c_CNT_WIDTH_DEFAULT,
  parameter int SUM_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  vid_stream_meas_if.slave     vid,
  input  logic                 err_clr_i,
  output logic [CNT_WIDTH-1:0] frame_w_o,
  output logic [CNT_WIDTH-1:0] frame_h_o,
  output logic [SUM_WIDTH-1:0] frame_sum_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o,
  output logic                 frame_done_o,
  output logic                 err_line_len_o,
  output logic                 err_de_blank_o
);

  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

  meas_state_t            state_q, state_d;
  logic [PIXEL_WIDTH-1:0] di_q, di_d;
  logic                   de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic                   in_vld_q, in_vld_d;
  logic [CNT_WIDTH-1:0]   pix_cnt_q, pix_cnt_d;
  logic [CNT_WIDTH-1:0]   line_w_q, line_w_d;
  logic [CNT_WIDTH-1:0]   line_h_q, line_h_d;
  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_WIDTH-1:0]   frame_w_q, frame_w_d;
  logic [CNT_WIDTH-1:0]   frame_h_q, frame_h_d;
  logic [SUM_WIDTH-1:0]   frame_sum_q, frame_sum_d;
  logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
  logic                   frame_done_q, frame_done_d;
  logic                   err_len_q, err_len_d;
  logic                   err_blank_q, err_blank_d;

  logic w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
  logic w_pix_acc, w_close_line, w_len_err, w_blank_err;

  vid_edge_det u_hs_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (hs_q),
    .rise_o (w_hs_rise),
    .fall_o (w_hs_fall)
  );

  vid_edge_det u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (vs_q),
    .rise_o (w_vs_rise),
    .fall_o (w_vs_fall)
  );

  always_comb begin
    di_d         = vid.di;
    de_d         = vid.de;
    hs_d         = vid.hs;
    vs_d         = vid.vs;
    in_vld_d     = 1'b1;
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    line_w_d     = line_w_q;
    line_h_d     = line_h_q;
    sum_d        = sum_q;
    frame_w_d    = frame_w_q;
    frame_h_d    = frame_h_q;
    frame_sum_d  = frame_sum_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    w_close_line = 1'b0;
    w_len_err    = 1'b0;
    w_pix_acc    = de_q & ~hs_q & vs_q & (state_q == LINE);

    case (state_q)
      // in_vld_q guards against the reset value of vs_q posing as a real blank
      SYNC: begin
        if (in_vld_q && !vs_q) state_d = IDLE;
      end
      IDLE: begin
        if (w_vs_rise) begin
          state_d   = FRAME;
          pix_cnt_d = '0;
          line_w_d  = '0;
          line_h_d  = '0;
          sum_d     = '0;
        end
      end
      FRAME: begin
        if (w_vs_fall) begin
          state_d = PUBLISH;
        end else if (w_hs_fall) begin
          state_d   = LINE;
          pix_cnt_d = '0;
        end
      end
      LINE: begin
        if (w_vs_fall) begin
          w_close_line = 1'b1;
          state_d      = PUBLISH;
        end else if (w_hs_rise) begin
          w_close_line = 1'b1;
          state_d      = FRAME;
        end
      end
      PUBLISH: begin
        frame_w_d    = line_w_q;
        frame_h_d    = line_h_q;
        frame_sum_d  = sum_q;
        frame_cnt_d  = (frame_cnt_q == c_CNT_MAX) ? frame_cnt_q : frame_cnt_q + 1'b1;
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = SYNC;
    endcase

    // Acceptance and line close never coincide: both edges imply a blank input
    if (w_pix_acc) begin
      pix_cnt_d = (pix_cnt_q == c_CNT_MAX) ? pix_cnt_q : pix_cnt_q + 1'b1;
      sum_d     = sum_q + SUM_WIDTH'(di_q);
    end

    if (w_close_line && (pix_cnt_q != '0)) begin
      line_h_d = (line_h_q == c_CNT_MAX) ? line_h_q : line_h_q + 1'b1;
      if (line_h_q == '0) begin
        line_w_d = pix_cnt_q;
      end else if (pix_cnt_q != line_w_q) begin
        w_len_err = 1'b1;
      end
    end

    w_blank_err = (state_q != SYNC) & de_q & (hs_q | ~vs_q);
    err_len_d   = (err_len_q & ~err_clr_i) | w_len_err;
    err_blank_d = (err_blank_q & ~err_clr_i) | w_blank_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      di_q         <= '0;
      de_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      in_vld_q     <= 1'b0;
      pix_cnt_q    <= '0;
      line_w_q     <= '0;
      line_h_q     <= '0;
      sum_q        <= '0;
      frame_w_q    <= '0;
      frame_h_q    <= '0;
      frame_sum_q  <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      err_len_q    <= 1'b0;
      err_blank_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      di_q         <= di_d;
      de_q         <= de_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      in_vld_q     <= in_vld_d;
      pix_cnt_q    <= pix_cnt_d;
      line_w_q     <= line_w_d;
      line_h_q     <= line_h_d;
      sum_q        <= sum_d;
      frame_w_q    <= frame_w_d;
      frame_h_q    <= frame_h_d;
      frame_sum_q  <= frame_sum_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      err_len_q    <= err_len_d;
      err_blank_q  <= err_blank_d;
    end
  end

  assign frame_w_o      = frame_w_q;
  assign frame_h_o      = frame_h_q;
  assign frame_sum_o    = frame_sum_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign frame_done_o   = frame_done_q;
  assign err_line_len_o = err_len_q;
  assign err_de_blank_o = err_blank_q;

endmodule
`default_nettype wire

// File: tb/tb_vid_stream_meas.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_vid_stream_meas : randomized frames checked against a frame-level model
// Rev 1.0
// ------------------------------------------------------------------
module tb_vid_stream_meas;

  localparam int PW = 8;
  localparam int CW = 16;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          err_clr = 1'b0;
  logic [CW-1:0] frame_w_o, frame_h_o, frame_cnt_o;
  logic [SW-1:0] frame_sum_o;
  logic          frame_done_o, err_line_len_o, err_de_blank_o;

  always #5 clk = ~clk;

  vid_stream_meas_if #(.PIXEL_WIDTH(PW)) vid ();

  vid_stream_meas #(
    .PIXEL_WIDTH (PW),
    .CNT_WIDTH   (CW),
    .SUM_WIDTH   (SW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .vid            (vid),
    .err_clr_i      (err_clr),
    .frame_w_o      (frame_w_o),
    .frame_h_o      (frame_h_o),
    .frame_sum_o    (frame_sum_o),
    .frame_cnt_o    (frame_cnt_o),
    .frame_done_o   (frame_done_o),
    .err_line_len_o (err_line_len_o),
    .err_de_blank_o (err_de_blank_o)
  );

  int checks   = 0;
  int failures = 0;
  int step_idx = 0;
  int done_cnt = 0;
  int done_at  = -1;
  logic [CW-1:0] cap_w, cap_h, cap_cnt;
  logic [SW-1:0] cap_sum;

  // frame-level reference state
  int lens[$];
  int exp_cnt       = 0;
  bit exp_err_len   = 1'b0;
  bit exp_err_blank = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, then drive the next input set
  task automatic step(input logic [7:0] di, input logic de, input logic hs, input logic vs);
    @(negedge clk);
    step_idx++;
    if (frame_done_o === 1'b1) begin
      done_cnt++;
      done_at = step_idx;
      cap_w   = frame_w_o;
      cap_h   = frame_h_o;
      cap_sum = frame_sum_o;
      cap_cnt = frame_cnt_o;
    end
    vid.di = di;
    vid.de = de;
    vid.hs = hs;
    vid.vs = vs;
  endtask

  task automatic fill(input int n, input int w);
    lens.delete();
    for (int i = 0; i < n; i++) lens.push_back(w);
  endtask

  // gap < 0 selects a random 0..3 idle cycles after every pixel
  task automatic send_frame(input int gap, input bit blank_de, input bit simul,
                            input bit rnd_px, input int abort_line, input string name);
    int          exp_w, exp_h, vs_fall_at, g;
    int unsigned exp_sum;
    bit          len_err, aborted, last;
    logic [7:0]  px;
    exp_w = 0; exp_h = 0; exp_sum = 0; len_err = 0; aborted = 0; vs_fall_at = 0;
    done_cnt = 0;
    done_at  = -1;
    repeat (4) step(8'h00, 1'b0, 1'b1, 1'b0);
    repeat (3) step(8'h00, 1'b0, 1'b1, 1'b1);
    for (int l = 0; l < lens.size(); l++) begin
      if (l == abort_line) begin
        rst = 1'b1;
        step(8'h00, 1'b0, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        aborted = 1'b1;
        exp_cnt = 0;
        exp_err_len = 1'b0;
        exp_err_blank = 1'b0;
      end
      step(8'h00, 1'b0, 1'b0, 1'b1);
      for (int x = 0; x < lens[l]; x++) begin
        px = rnd_px ? 8'($urandom_range(0, 255)) : 8'(x + l);
        step(px, 1'b1, 1'b0, 1'b1);
        exp_sum += px;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (g) step(px ^ 8'h5a, 1'b0, 1'b0, 1'b1);
      end
      if (lens[l] > 0) begin
        if (exp_h == 0) exp_w = lens[l];
        else if (lens[l] != exp_w) len_err = 1'b1;
        exp_h++;
      end
      last = (l == lens.size() - 1);
      if (last && simul) begin
        vs_fall_at = step_idx + 1;
        step(8'h00, 1'b0, 1'b1, 1'b0);
      end else begin
        if (blank_de && l == 0) begin
          step(8'hff, 1'b1, 1'b1, 1'b1);
          exp_err_blank = 1'b1;
        end else begin
          step(8'h00, 1'b0, 1'b1, 1'b1);
        end
        repeat (2) step(8'h00, 1'b0, 1'b1, 1'b1);
      end
    end
    if (!(simul && lens.size() > 0)) begin
      vs_fall_at = step_idx + 1;
      step(8'h00, 1'b0, 1'b1, 1'b0);
    end
    repeat (8) step(8'h00, 1'b0, 1'b1, 1'b0);
    if (aborted) begin
      check({name, " done_cnt"}, 64'(done_cnt), 64'd0);
    end else begin
      exp_cnt++;
      exp_err_len |= len_err;
      check({name, " done_cnt"}, 64'(done_cnt), 64'd1);
      check({name, " latency"}, 64'(done_at - vs_fall_at), 64'd3);
      check({name, " w"}, 64'(cap_w), 64'(exp_w));
      check({name, " h"}, 64'(cap_h), 64'(exp_h));
      check({name, " sum"}, 64'(cap_sum), 64'(exp_sum));
      check({name, " cnt"}, 64'(cap_cnt), 64'(exp_cnt));
    end
    check({name, " err_line_len"}, 64'(err_line_len_o), 64'(exp_err_len));
    check({name, " err_de_blank"}, 64'(err_de_blank_o), 64'(exp_err_blank));
  endtask

  task automatic clr_err(input string name);
    err_clr = 1'b1;
    step(8'h00, 1'b0, 1'b1, 1'b0);
    err_clr = 1'b0;
    exp_err_len = 1'b0;
    exp_err_blank = 1'b0;
    step(8'h00, 1'b0, 1'b1, 1'b0);
    check({name, " clr err_line_len"}, 64'(err_line_len_o), 64'd0);
    check({name, " clr err_de_blank"}, 64'(err_de_blank_o), 64'd0);
  endtask

  initial begin
    vid.di = '0;
    vid.de = 1'b0;
    vid.hs = 1'b1;
    vid.vs = 1'b0;
    rst = 1'b1;
    repeat (3) step(8'h00, 1'b0, 1'b1, 1'b0);
    check("rst frame_w", 64'(frame_w_o), 64'd0);
    check("rst frame_h", 64'(frame_h_o), 64'd0);
    check("rst frame_sum", 64'(frame_sum_o), 64'd0);
    check("rst frame_cnt", 64'(frame_cnt_o), 64'd0);
    check("rst frame_done", 64'(frame_done_o), 64'd0);
    check("rst err_line_len", 64'(err_line_len_o), 64'd0);
    check("rst err_de_blank", 64'(err_de_blank_o), 64'd0);
    rst = 1'b0;
    step(8'h00, 1'b0, 1'b1, 1'b0);

    fill(24, 24);
    send_frame(0, 1'b0, 1'b0, 1'b0, -1, "dense");
    send_frame(3, 1'b0, 1'b0, 1'b0, -1, "sparse");

    fill(24, 24);
    lens[5] = 23;
    send_frame(0, 1'b0, 1'b0, 1'b0, -1, "short_line");
    clr_err("short_line");

    fill(24, 24);
    send_frame(0, 1'b1, 1'b0, 1'b0, -1, "blank_de");
    clr_err("blank_de");

    send_frame(0, 1'b0, 1'b1, 1'b0, -1, "simul_last");

    send_frame(0, 1'b0, 1'b0, 1'b0, 10, "abort");
    send_frame(0, 1'b0, 1'b0, 1'b0, -1, "after_abort");

    lens.delete();
    send_frame(0, 1'b0, 1'b0, 1'b0, -1, "no_lines");

    lens = '{0, 5, 0, 5, 5, 0};
    send_frame(-1, 1'b0, 1'b0, 1'b1, -1, "empty_lines");

    for (int f = 0; f < 8; f++) begin
      int n, w;
      n = int'($urandom_range(1, 7));
      w = int'($urandom_range(1, 10));
      lens.delete();
      for (int i = 0; i < n; i++)
        lens.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : w);
      send_frame(-1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, -1,
                 $sformatf("rand%0d", f));
      clr_err($sformatf("rand%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
